// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side signal bundle for ram_arbiter.
// slave is the arbiter's view; master is the requesters-plus-RAM environment.
interface ram_arbiter_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
);
   logic                  i_req0;
   logic                  i_req1;
   logic                  i_we0;
   logic                  i_we1;
   logic [ADDR_WIDTH-1:0] i_addr0;
   logic [ADDR_WIDTH-1:0] i_addr1;
   logic [DATA_WIDTH-1:0] i_wdata0;
   logic [DATA_WIDTH-1:0] i_wdata1;
   logic                  o_ack0;
   logic                  o_ack1;
   logic                  o_rvalid0;
   logic                  o_rvalid1;
   logic [DATA_WIDTH-1:0] o_rdata0;
   logic [DATA_WIDTH-1:0] o_rdata1;
   logic                  o_ram_load;
   logic [ADDR_WIDTH-1:0] o_ram_addr;
   logic [DATA_WIDTH-1:0] o_ram_data;
   logic [DATA_WIDTH-1:0] i_ram_data;
   logic                  o_busy;

   modport slave (
      input  i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1, i_wdata0, i_wdata1,
      input  i_ram_data,
      output o_ack0, o_ack1, o_rvalid0, o_rvalid1, o_rdata0, o_rdata1,
      output o_ram_load, o_ram_addr, o_ram_data, o_busy
   );

   modport master (
      output i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1, i_wdata0, i_wdata1,
      output i_ram_data,
      input  o_ack0, o_ack1, o_rvalid0, o_rvalid1, o_rdata0, o_rdata1,
      input  o_ram_load, o_ram_addr, o_ram_data, o_busy
   );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// A request is captured in IDLE, issued to the RAM for one cycle, and a read returns two cycles later.
module ram_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
) (
   input  logic         i_clk,
   input  logic         i_rst,
   ram_arbiter_if.slave bus,
   output logic [1:0]   o_dbg_state
);

   // Handshake: a requester raises i_reqN with we/addr/wdata stable and holds them
   // until it sees o_ackN (the single RAM issue cycle), dropping i_reqN the cycle after.
   // A read then answers with a one-cycle o_rvalidN; o_rdataN holds until that
   // port's next read completes. Requests are only looked at while IDLE.

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      READ_WAIT = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  r_gnt;
   logic                  r_last;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata0;
   logic [DATA_WIDTH-1:0] r_rdata1;
   logic                  r_rvalid0;
   logic                  r_rvalid1;

   logic                  w_any_req;
   logic                  w_gnt_idx;
   logic                  w_capture;
   logic                  w_read_done;
   logic                  w_ack0;
   logic                  w_ack1;
   logic                  w_ram_load;
   logic                  w_busy;

   assign w_any_req = bus.i_req0 | bus.i_req1;

   // On contention the port that did not win last time gets the grant.
   always_comb begin
      w_gnt_idx = 1'b0;
      if (bus.i_req0 && bus.i_req1) begin
         w_gnt_idx = ~r_last;
      end else if (bus.i_req1) begin
         w_gnt_idx = 1'b1;
      end
   end

   assign w_capture   = (r_state == IDLE) && w_any_req;
   assign w_read_done = (r_state == READ_WAIT);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:      if (w_any_req) w_next = ISSUE;
         ISSUE:     w_next = r_we ? IDLE : READ_WAIT;
         READ_WAIT: w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   always_comb begin
      w_ack0     = 1'b0;
      w_ack1     = 1'b0;
      w_ram_load = 1'b0;
      w_busy     = 1'b0;
      case (r_state)
         ISSUE: begin
            w_ack0     = ~r_gnt;
            w_ack1     = r_gnt;
            w_ram_load = r_we;
            w_busy     = 1'b1;
         end
         READ_WAIT: w_busy = 1'b1;
         default: ;
      endcase
   end

   // r_addr/r_wdata drive the RAM directly, so they keep their value outside ISSUE.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_gnt   <= 1'b0;
         r_last  <= 1'b1;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_capture) begin
         r_gnt   <= w_gnt_idx;
         r_last  <= w_gnt_idx;
         r_we    <= w_gnt_idx ? bus.i_we1    : bus.i_we0;
         r_addr  <= w_gnt_idx ? bus.i_addr1  : bus.i_addr0;
         r_wdata <= w_gnt_idx ? bus.i_wdata1 : bus.i_wdata0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
         r_rdata0  <= '0;
         r_rdata1  <= '0;
      end else begin
         r_rvalid0 <= w_read_done && !r_gnt;
         r_rvalid1 <= w_read_done && r_gnt;
         if (w_read_done && !r_gnt) r_rdata0 <= bus.i_ram_data;
         if (w_read_done && r_gnt)  r_rdata1 <= bus.i_ram_data;
      end
   end

   assign bus.o_ack0     = w_ack0;
   assign bus.o_ack1     = w_ack1;
   assign bus.o_rvalid0  = r_rvalid0;
   assign bus.o_rvalid1  = r_rvalid1;
   assign bus.o_rdata0   = r_rdata0;
   assign bus.o_rdata1   = r_rdata1;
   assign bus.o_ram_load = w_ram_load;
   assign bus.o_ram_addr = r_addr;
   assign bus.o_ram_data = r_wdata;
   assign bus.o_busy     = w_busy;
   assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios and random traffic, both scheduled by a
// transaction-level model that predicts every output cycle by cycle.
module tb_ram_arbiter;
   localparam int AW   = 8;
   localparam int DW   = 16;
   localparam int MAXC = 512;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            gap;
      logic          early;
   } txn_t;

   // ---------------- clock / reset ----------------
   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic       preload = 1'b1;
   logic [1:0] dbg_state;
   int         n_check = 0;
   int         n_pass  = 0;
   int         n_fail  = 0;
   int         cur_cyc = 0;

   always #5 clk = ~clk;

   ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .bus        (bus),
      .o_dbg_state(dbg_state)
   );

   function automatic logic [DW-1:0] init_val(input int i);
      return DW'(i * 40503) ^ 16'h5A5A;
   endfunction

   // Synchronous RAM: data for the address sampled at an edge appears after that edge.
   logic [DW-1:0] ram [256];
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      end else if (bus.o_ram_load) begin
         ram[bus.o_ram_addr] <= bus.o_ram_data;
      end
      bus.i_ram_data <= ram[bus.o_ram_addr];
   end

   // ---------------- reference model state ----------------
   logic [DW-1:0] m_mem [256];
   int            m_last;
   logic [DW-1:0] m_rd [2];
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   logic [DW-1:0] exp_q [$];
   txn_t          q0 [$];
   txn_t          q1 [$];
   int            seg_len;

   logic          d_req   [2][MAXC];
   logic          d_we    [2][MAXC];
   logic [AW-1:0] d_addr  [2][MAXC];
   logic [DW-1:0] d_wdata [2][MAXC];
   logic          e_ack   [2][MAXC];
   logic          e_rv    [2][MAXC];
   logic          e_load  [MAXC];
   logic          e_busy  [MAXC];
   logic          e_iss   [MAXC];
   logic [AW-1:0] e_ad    [MAXC];
   logic [DW-1:0] e_wd    [MAXC];

   // ---------------- scoreboard ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_check++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s cyc %0d: observed %0h expected %0h", tag, cur_cyc, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string pfx);
      chk({pfx, "_ack0"},     32'(bus.o_ack0),     32'd0);
      chk({pfx, "_ack1"},     32'(bus.o_ack1),     32'd0);
      chk({pfx, "_rvalid0"},  32'(bus.o_rvalid0),  32'd0);
      chk({pfx, "_rvalid1"},  32'(bus.o_rvalid1),  32'd0);
      chk({pfx, "_rdata0"},   32'(bus.o_rdata0),   32'd0);
      chk({pfx, "_rdata1"},   32'(bus.o_rdata1),   32'd0);
      chk({pfx, "_ram_load"}, 32'(bus.o_ram_load), 32'd0);
      chk({pfx, "_ram_addr"}, 32'(bus.o_ram_addr), 32'd0);
      chk({pfx, "_ram_data"}, 32'(bus.o_ram_data), 32'd0);
      chk({pfx, "_busy"},     32'(bus.o_busy),     32'd0);
   endtask

   // ---------------- driver tasks ----------------
   task automatic add(input int port, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input int gap, input logic early);
      txn_t t;
      t.we = we; t.addr = a; t.wdata = d; t.gap = gap; t.early = early;
      if (port == 0) q0.push_back(t);
      else q1.push_back(t);
   endtask

   // Serialises queued transactions: one service slot at a time, round-robin on ties,
   // ack one cycle after sampling, write slot 2 cycles, read slot 3 cycles.
   task automatic plan();
      int   pos [2];
      int   raise [2];
      int   nq [2];
      int   free_c;
      int   s;
      int   g;
      int   mn;
      int   last_c;
      bit   cand [2];
      txn_t t;
      for (int c = 0; c < MAXC; c++) begin
         for (int k = 0; k < 2; k++) begin
            d_req[k][c]   = 1'b0;
            d_we[k][c]    = 1'($urandom_range(0, 1));
            d_addr[k][c]  = AW'($urandom);
            d_wdata[k][c] = DW'($urandom);
            e_ack[k][c]   = 1'b0;
            e_rv[k][c]    = 1'b0;
         end
         e_load[c] = 1'b0;
         e_busy[c] = 1'b0;
         e_iss[c]  = 1'b0;
         e_ad[c]   = '0;
         e_wd[c]   = '0;
      end
      nq[0] = q0.size();
      nq[1] = q1.size();
      pos[0] = 0;
      pos[1] = 0;
      raise[0] = (nq[0] > 0) ? q0[0].gap : 0;
      raise[1] = (nq[1] > 0) ? q1[0].gap : 0;
      free_c = 0;
      while (pos[0] < nq[0] || pos[1] < nq[1]) begin
         mn = MAXC;
         for (int k = 0; k < 2; k++) if (pos[k] < nq[k] && raise[k] < mn) mn = raise[k];
         s = (mn > free_c) ? mn : free_c;
         for (int k = 0; k < 2; k++) cand[k] = (pos[k] < nq[k]) && (raise[k] <= s);
         if (cand[0] && cand[1]) g = 1 - m_last;
         else g = cand[0] ? 0 : 1;
         m_last = g;
         t = (g == 0) ? q0[pos[0]] : q1[pos[1]];
         last_c = t.early ? s : s + 1;
         for (int c = raise[g]; c <= last_c; c++) begin
            d_req[g][c]   = 1'b1;
            d_we[g][c]    = t.we;
            d_addr[g][c]  = t.addr;
            d_wdata[g][c] = t.wdata;
         end
         e_ack[g][s+1] = 1'b1;
         e_iss[s+1]    = 1'b1;
         e_ad[s+1]     = t.addr;
         e_wd[s+1]     = t.wdata;
         e_load[s+1]   = t.we;
         e_busy[s+1]   = 1'b1;
         if (t.we) begin
            m_mem[t.addr] = t.wdata;
            free_c = s + 2;
         end else begin
            e_busy[s+2]   = 1'b1;
            e_rv[g][s+3]  = 1'b1;
            exp_q.push_back(m_mem[t.addr]);
            free_c = s + 3;
         end
         pos[g]++;
         if (pos[g] < nq[g]) raise[g] = s + 3 + ((g == 0) ? q0[pos[0]].gap : q1[pos[1]].gap);
      end
      seg_len = free_c + 3;
   endtask

   // Entered at a falling edge: check cycle c, then drive cycle c's inputs.
   task automatic run_seg();
      for (int c = 0; c < seg_len; c++) begin
         cur_cyc = c;
         if (e_iss[c]) begin
            m_addr = e_ad[c];
            m_data = e_wd[c];
         end
         for (int k = 0; k < 2; k++) if (e_rv[k][c]) m_rd[k] = exp_q.pop_front();
         chk("ack0",     32'(bus.o_ack0),     32'(e_ack[0][c]));
         chk("ack1",     32'(bus.o_ack1),     32'(e_ack[1][c]));
         chk("rvalid0",  32'(bus.o_rvalid0),  32'(e_rv[0][c]));
         chk("rvalid1",  32'(bus.o_rvalid1),  32'(e_rv[1][c]));
         chk("rdata0",   32'(bus.o_rdata0),   32'(m_rd[0]));
         chk("rdata1",   32'(bus.o_rdata1),   32'(m_rd[1]));
         chk("ram_load", 32'(bus.o_ram_load), 32'(e_load[c]));
         chk("busy",     32'(bus.o_busy),     32'(e_busy[c]));
         chk("ram_addr", 32'(bus.o_ram_addr), 32'(m_addr));
         chk("ram_data", 32'(bus.o_ram_data), 32'(m_data));
         bus.i_req0   = d_req[0][c];
         bus.i_we0    = d_we[0][c];
         bus.i_addr0  = d_addr[0][c];
         bus.i_wdata0 = d_wdata[0][c];
         bus.i_req1   = d_req[1][c];
         bus.i_we1    = d_we[1][c];
         bus.i_addr1  = d_addr[1][c];
         bus.i_wdata1 = d_wdata[1][c];
         @(negedge clk);
      end
      bus.i_req0 = 1'b0;
      bus.i_req1 = 1'b0;
   endtask

   task automatic go();
      plan();
      run_seg();
      q0.delete();
      q1.delete();
   endtask

   // ---------------- directed and random steps ----------------
   initial begin
      bus.i_req0 = 1'b0; bus.i_we0 = 1'b0; bus.i_addr0 = '0; bus.i_wdata0 = '0;
      bus.i_req1 = 1'b0; bus.i_we1 = 1'b0; bus.i_addr1 = '0; bus.i_wdata1 = '0;
      m_last = 1;
      m_rd[0] = '0;
      m_rd[1] = '0;
      m_addr = '0;
      m_data = '0;
      for (int i = 0; i < 256; i++) m_mem[i] = init_val(i);

      repeat (3) @(negedge clk);
      cur_cyc = -1;
      chk_all_zero("reset");
      preload = 1'b0;
      rst     = 1'b0;

      // Simultaneous reads straight out of reset: port 0 wins, port 1 follows its rvalid.
      add(0, 1'b0, 8'h21, DW'($urandom), 0, 1'b0);
      add(1, 1'b0, 8'h35, DW'($urandom), 0, 1'b0);
      go();

      // Write then read back on port 0.
      add(0, 1'b1, 8'h10, 16'hBEEF, 0, 1'b0);
      add(0, 1'b0, 8'h10, DW'($urandom), 0, 1'b0);
      go();

      // Four back-to-back reads per port under continuous contention.
      for (int i = 0; i < 4; i++) begin
         add(0, 1'b0, AW'(8'h10 + i), DW'($urandom), 0, 1'b0);
         add(1, 1'b0, AW'(8'h80 + i), DW'($urandom), 0, 1'b0);
      end
      go();

      // Top address on port 1.
      add(1, 1'b1, 8'hFF, 16'h1234, 0, 1'b0);
      add(1, 1'b0, 8'hFF, DW'($urandom), 0, 1'b0);
      go();

      // Port 0 drops its request right after capture.
      add(0, 1'b0, 8'h10, DW'($urandom), 0, 1'b1);
      go();

      // Reset while a port 1 read sits in READ_WAIT.
      cur_cyc = 0;
      bus.i_req1 = 1'b1; bus.i_we1 = 1'b0; bus.i_addr1 = 8'hFF; bus.i_wdata1 = DW'($urandom);
      @(negedge clk);
      cur_cyc = 1;
      chk("abort_ack1", 32'(bus.o_ack1), 32'd1);
      chk("abort_busy_issue", 32'(bus.o_busy), 32'd1);
      @(negedge clk);
      cur_cyc = 2;
      bus.i_req1 = 1'b0;
      chk("abort_busy_wait", 32'(bus.o_busy), 32'd1);
      #2 rst = 1'b1;
      #1 chk_all_zero("abort");
      @(negedge clk);
      rst = 1'b0;
      m_last = 1;
      m_rd[0] = '0;
      m_rd[1] = '0;
      m_addr = '0;
      m_data = '0;
      for (int i = 0; i < 4; i++) begin
         cur_cyc = 3 + i;
         chk("abort_rvalid1", 32'(bus.o_rvalid1), 32'd0);
         chk("abort_idle", 32'(bus.o_busy), 32'd0);
         chk("abort_rdata1", 32'(bus.o_rdata1), 32'd0);
         @(negedge clk);
      end
      add(1, 1'b0, 8'hFF, DW'($urandom), 0, 1'b0);
      go();

      // Random mixed traffic.
      for (int r = 0; r < 10; r++) begin
         int n0;
         int n1;
         n0 = $urandom_range(0, 8);
         n1 = $urandom_range(0, 8);
         for (int i = 0; i < n0; i++)
            add(0, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom),
                DW'($urandom), $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
         for (int i = 0; i < n1; i++)
            add(1, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom),
                DW'($urandom), $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
         go();
      end

      $display("%0d/%0d checks passed", n_pass, n_check);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, data RAM address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, data word width.
REQ-003 The block SHALL have port i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have ports i_req0/i_req1  input  1  requester 0/1 access request, held until ack.
REQ-006 The block SHALL have ports i_we0/i_we1  input  1  1 = write, 0 = read.
REQ-007 The block SHALL have ports i_addr0/i_addr1  input  ADDR_WIDTH  access address.
REQ-008 The block SHALL have ports i_wdata0/i_wdata1  input  DATA_WIDTH  write data.
REQ-009 The block SHALL have ports o_ack0/o_ack1  output  1  one-cycle pulse, request issued to RAM.
REQ-010 The block SHALL have ports o_rvalid0/o_rvalid1  output  1  one-cycle pulse, o_rdataN valid.
REQ-011 The block SHALL have ports o_rdata0/o_rdata1  output  DATA_WIDTH  read data, held until that port's next read completes.
REQ-012 The block SHALL have port o_ram_load  output  1  RAM write enable.
REQ-013 The block SHALL have port o_ram_addr  output  ADDR_WIDTH  RAM address.
REQ-014 The block SHALL have port o_ram_data  output  DATA_WIDTH  RAM write data.
REQ-015 The block SHALL have port i_ram_data  input  DATA_WIDTH  RAM read data, valid one cycle after the address is sampled.
REQ-016 The block SHALL have port o_busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE and READ_WAIT.
REQ-018 In IDLE with any i_reqN high, the block SHALL latch the granted requester's index, we, addr and wdata, then go to ISSUE.
REQ-019 With exactly one request in IDLE, the block SHALL grant that requester.
REQ-020 With both requests in IDLE, the block SHALL grant the requester not granted last (round-robin), so continuous contention alternates grants.
REQ-021 In ISSUE, o_ram_addr and o_ram_data SHALL equal the latched values, o_ram_load SHALL equal the latched we, and o_ackN SHALL be high for the granted N only.
REQ-022 From ISSUE, a write SHALL go to IDLE and a read SHALL go to READ_WAIT.
REQ-023 At the end of READ_WAIT, the block SHALL load o_rdataN from i_ram_data, pulse o_rvalidN high for the following cycle, and go to IDLE.
REQ-024 Outside ISSUE, o_ram_load SHALL be 0. o_ram_addr and o_ram_data SHALL hold their last values.
REQ-025 Read latency SHALL be: req sampled in IDLE at cycle T, then ack at T+1, then rvalid at T+3.
REQ-026 Write latency SHALL be: ack at T+1 with RAM written at the end of T+1, and the block back in IDLE at T+2.
REQ-027 A new request SHALL be accepted in the same IDLE cycle that o_rvalidN is high.
REQ-028 Requests SHALL be sampled only in IDLE; a req high in ISSUE or READ_WAIT SHALL be ignored until IDLE.
REQ-029 A requester SHALL hold req, we, addr and wdata stable until it samples ack, and SHALL drop req the cycle after ack.
REQ-030 If a requester drops req after capture, the captured transaction SHALL still complete, including rvalid.
REQ-031 At most one o_ackN and at most one o_rvalidN SHALL be high in any cycle.

Reset
REQ-032 i_rst SHALL immediately force state to IDLE and all outputs to 0: ack, rvalid, rdata, ram_load, ram_addr, ram_data and busy.
REQ-033 i_rst SHALL set last-granted to 1, so requester 0 wins the first tie.
REQ-034 Reset asserted in ISSUE or READ_WAIT SHALL abort the transaction with no ack and no rvalid; RAM contents SHALL be untouched by the arbiter beyond writes already completed.
REQ-035 The first request SHALL be sampled on the first rising edge after i_rst deasserts.

Verification
REQ-036 Bench: req0 write addr 0x10 data 0xBEEF, then req0 read 0x10 -> o_ack0 at T+1 for each; o_rvalid0 at T+3 of the read with o_rdata0 = 0xBEEF.
REQ-037 Bench: req0 and req1 reads raised in the same cycle right after reset -> port 0 granted first; port 1 ack arrives in the cycle after port 0 rvalid.
REQ-038 Bench: both requesters issue 4 back-to-back reads -> grants strictly alternate 0,1,0,1,... and o_rdata1 keeps its value while port 0 completes.
REQ-039 Bench: i_rst pulsed in READ_WAIT of a port 1 read -> no o_rvalid1, all outputs 0 asynchronously, and the next req1 completes normally.
REQ-040 Bench: req1 write 0x1234 to 0xFF, then read 0xFF -> o_ram_load high exactly 1 cycle and o_rdata1 = 0x1234 (address upper bound).
REQ-041 Bench: req0 dropped the cycle after capture -> o_ack0 and o_rvalid0 still occur at T+1 and T+3.
